// File: rtl/interval_timer_arbiter.sv
// interval_timer_arbiter: round-robin arbiter sharing one interval counter.
// Winner holds a one-hot grant for len cycles, then gets a done pulse.
module interval_timer_arbiter #(
  parameter int NREQ      = 4,
  parameter int CNT_W     = 4,
  parameter int MAX_COUNT = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] len,
  input  logic [NREQ-1:0]       cancel,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [CNT_W-1:0]      count,
  output logic [NREQ-1:0]       done,
  output logic [NREQ-1:0]       err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state, state_d;
  logic [PW-1:0]    rr_ptr, rr_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [NREQ-1:0]  gnt_d, done_d, err_d;
  logic             busy_d;
  logic [CNT_W-1:0] count_d;

  logic             found;
  logic [PW-1:0]    win;
  logic [PW:0]      sum;
  logic [CNT_W-1:0] win_len;
  logic             bad;
  logic [NREQ-1:0]  win_oh;
  logic [PW-1:0]    rr_next;

  // First requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(NREQ))
        sum = sum - (PW+1)'(NREQ);
      if (!found && req[sum]) begin
        found = 1'b1;
        win   = sum[PW-1:0];
      end
    end
  end

  assign win_len = len[int'(win)*CNT_W +: CNT_W];
  assign bad     = (win_len == '0) ||
                   (win_len > CNT_W'(MAX_COUNT));
  assign win_oh  = NREQ'(1) << win;
  assign rr_next = (win == PW'(NREQ-1)) ?
                   '0 : win + PW'(1);

  always_comb begin
    state_d = state;
    rr_d    = rr_ptr;
    len_d   = len_q;
    gnt_d   = gnt;
    busy_d  = busy;
    count_d = count;
    done_d  = '0;
    err_d   = '0;
    unique case (state)
      S_IDLE: begin
        if (found) begin
          rr_d  = rr_next;
          len_d = win_len;
          if (bad) begin
            err_d = win_oh;
          end else begin
            state_d = S_RUN;
            gnt_d   = win_oh;
            busy_d  = 1'b1;
            count_d = '0;
          end
        end
      end
      S_RUN: begin
        // Cancel beats completion on the final count cycle.
        if (|(cancel & gnt)) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          count_d = '0;
        end else if (count == len_q - CNT_W'(1)) begin
          state_d = S_DONE;
          done_d  = gnt;
          gnt_d   = '0;
          busy_d  = 1'b0;
          count_d = '0;
        end else begin
          count_d = count + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
      len_q  <= '0;
      gnt    <= '0;
      busy   <= 1'b0;
      count  <= '0;
      done   <= '0;
      err    <= '0;
    end else begin
      rr_ptr <= rr_d;
      len_q  <= len_d;
      gnt    <= gnt_d;
      busy   <= busy_d;
      count  <= count_d;
      done   <= done_d;
      err    <= err_d;
    end
  end

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// tb_interval_timer_arbiter: directed bench for interval_timer_arbiter.
// Outputs are sampled on the falling clock edge.
module tb_interval_timer_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] len;
  logic [3:0]  cancel;
  logic [3:0]  gnt;
  logic        busy;
  logic [3:0]  count;
  logic [3:0]  done;
  logic [3:0]  err;

  int n_chk;
  int n_fail;

  interval_timer_arbiter #(
    .NREQ(4),
    .CNT_W(4),
    .MAX_COUNT(14)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .len(len),
    .cancel(cancel),
    .gnt(gnt),
    .busy(busy),
    .count(count),
    .done(done),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk("inv_busy", 32'(busy), 32'(|gnt));
      chk("inv_onehot", 32'($countones(gnt) > 1), 0);
      chk("inv_done_err", 32'(done & err), 0);
    end
  end

  task automatic grant_seq(input logic [3:0] exp,
                           input int n);
    int t;
    t = 0;
    while (gnt == '0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("gap", t, 1);
    chk("err_in_run", 32'(err), 0);
    for (int k = 0; k < n; k++) begin
      chk("gnt", 32'(gnt), 32'(exp));
      chk("count", 32'(count), k);
      chk("busy", 32'(busy), 1);
      chk("done_early", 32'(done), 0);
      @(negedge clk);
    end
    chk("gnt_off", 32'(gnt), 0);
    chk("done", 32'(done), 32'(exp));
    chk("busy_off", 32'(busy), 0);
    @(negedge clk);
    chk("done_pulse", 32'(done), 0);
    chk("gnt_gap", 32'(gnt), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b0;
    req    = '0;
    len    = '0;
    cancel = '0;
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // single requester, len 5
    req = 4'b0001;
    len = {4'd0, 4'd0, 4'd0, 4'd5};
    grant_seq(4'b0001, 5);
    req = '0;

    // round robin from rr_ptr 0
    do_reset();
    req = 4'b0101;
    len = {4'd3, 4'd3, 4'd3, 4'd3};
    grant_seq(4'b0001, 3);
    grant_seq(4'b0100, 3);
    req = 4'b1111;
    grant_seq(4'b1000, 3);
    grant_seq(4'b0001, 3);
    grant_seq(4'b0010, 3);
    grant_seq(4'b0100, 3);
    req = '0;

    // illegal lengths, then the largest legal one
    @(negedge clk);
    req = 4'b0010;
    len = {4'd0, 4'd0, 4'd0, 4'd0};
    @(negedge clk);
    chk("err_len0", 32'(err), 32'h2);
    chk("err_len0_gnt", 32'(gnt), 0);
    len = {4'd0, 4'd0, 4'd15, 4'd0};
    @(negedge clk);
    chk("err_len15", 32'(err), 32'h2);
    chk("err_len15_gnt", 32'(gnt), 0);
    len = {4'd0, 4'd0, 4'd14, 4'd0};
    grant_seq(4'b0010, 14);
    req = '0;

    // cancel mid-interval and on the final count cycle
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      req = 4'b0001;
      len = (c == 0) ? 16'h0005 : 16'h0003;
      @(negedge clk);
      chk("cx_gnt", 32'(gnt), 1);
      req = '0;
      @(negedge clk);
      @(negedge clk);
      chk("cx_count", 32'(count), 2);
      cancel = 4'b0001;
      @(negedge clk);
      cancel = '0;
      chk("cx_gnt_off", 32'(gnt), 0);
      chk("cx_busy", 32'(busy), 0);
      chk("cx_count0", 32'(count), 0);
      chk("cx_no_done", 32'(done), 0);
      @(negedge clk);
      chk("cx_no_done2", 32'(done), 0);
      chk("cx_idle", 32'(gnt), 0);
    end

    // cancel on a non-granted index is ignored
    cancel = 4'b0010;
    req = 4'b0001;
    len = 16'h0003;
    grant_seq(4'b0001, 3);
    req = '0;
    cancel = '0;

    // asynchronous reset mid-run, then grant restarts at 0
    @(negedge clk);
    req = 4'b1111;
    len = {4'd5, 4'd5, 4'd5, 4'd5};
    @(negedge clk);
    chk("pre_rst_gnt", 32'(gnt), 32'h2);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_count", 32'(count), 3);
    #2;
    reset = 1'b0;
    #1;
    chk("async_gnt", 32'(gnt), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_count", 32'(count), 0);
    chk("async_done", 32'(done), 0);
    chk("async_err", 32'(err), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    grant_seq(4'b0001, 5);
    req = '0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
